alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Issue side of the ALU sub-unit interface (Arith/Logic/CMP/Shift units).
//  Accepts an op (A, B, 4-bit ALU_FUN) via valid/ready and decodes it to one sub-unit.
//  Pulses that unit's Enable, captures its registered OUT/Flag and returns the result via valid/ready.
//  Sits between the ALU top-level request port and the four sub-unit instances.
// PARAMETERS
//  IN_DATA_WIDTH   16  operand width driven to the sub-units
//  OUT_DATA_WIDTH  16  result width captured from the sub-units
//  TIMEOUT_CYCLES  4   WAIT cycles allowed for the selected Flag before error (>=1)
// PORTS
//  CLK            in   1    clock, rising edge
//  RST            in   1    asynchronous reset, active-low
//  Req_Valid      in   1    op request present
//  Req_Ready      out  1    sequencer can accept (state IDLE)
//  Req_A, Req_B   in   IDW  operands
//  Req_FUN        in   4    [3:2] unit: 00 arith, 01 logic, 10 cmp, 11 shift; [1:0] sub-op
//  A, B           out  IDW  latched operands to all sub-units
//  ALU_FUN        out  2    latched Req_FUN[1:0] to all sub-units
//  Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out 1 each  one-cycle issue pulse
//  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT              in  ODW     sub-unit results
//  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag          in  1       sub-unit result-valid
//  ALU_OUT        out  ODW  captured result (held while Out_Valid)
//  Out_Valid      out  1    result available
//  Out_Ready      in   1    downstream accepts result
//  Timeout_Err    out  1    qualifies ALU_OUT: selected Flag never arrived
// BEHAVIOUR
//  Reset (async, RST=0): state IDLE; A, B, ALU_FUN, ALU_OUT = 0; all Enables, Out_Valid, Timeout_Err = 0; counter = 0.
//   Enables drop immediately on reset, also mid-operation; the in-flight op is discarded.
//  FSM IDLE -> ISSUE -> WAIT -> HOLD -> IDLE. All outputs registered.
//   IDLE : Req_Ready=1. On Req_Valid: latch A, B, FUN into A/B/ALU_FUN/unit-select; -> ISSUE.
//   ISSUE: exactly the selected Enable = 1 for this one cycle; counter cleared; -> WAIT.
//   WAIT : watch only the selected unit's Flag; Flags of other units are ignored.
//          Flag=1: ALU_OUT <= selected OUT, Timeout_Err <= 0, Out_Valid <= 1; -> HOLD.
//          Else counter++. At counter==TIMEOUT_CYCLES-1 without Flag: ALU_OUT <= 0, Timeout_Err <= 1, Out_Valid <= 1; -> HOLD.
//          Flag and timeout in the same cycle: Flag wins.
//   HOLD : ALU_OUT/Timeout_Err/Out_Valid stable until Out_Ready=1; at that edge Out_Valid <= 0; -> IDLE.
//  Latency: request accepted at edge k, Enable high during k..k+1, Flag sampled at edge k+2, Out_Valid=1 after edge k+2.
//   Min spacing between accepts is 4 cycles (no overlap; Req_Ready=0 outside IDLE).
//  Sub-unit Flags are one-cycle pulses (Flag <= Enable). Capture in WAIT must not require Flag to persist.
//  A/B/ALU_FUN are held from accept until the next accept; changes on Req_* outside IDLE are ignored.
//  Widths: ALU_OUT is ODW; a captured OUT is assigned directly with no extension or truncation.
// STRUCTURE
//  Shared package alu_pkg:
//   - unit-select encoding constants (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11)
//   - FSM state encoding
//   - default widths
//  One natural sub-module alu_unit_mux: combinational 4:1 select of {OUT, Flag} by unit-select.
//  FSM, counter and registers live in alu_op_sequencer.
// TESTING (bench models the four units as Flag/OUT registered one cycle after Enable)
//  1. Req_FUN=4'b1101, A=16'h8001 -> Shift_Enable pulse 1 cycle, ALU_FUN=01; ALU_OUT=16'h0002, Out_Valid after edge k+2, Timeout_Err=0.
//  2. Req_FUN=4'b0000, A=5, B=7, arith model returns 12 -> only Arith_Enable pulses; ALU_OUT=16'h000C.
//  3. Out_Ready held 0 for 5 cycles -> ALU_OUT/Out_Valid stable, Req_Ready=0, new Req_Valid ignored; Out_Ready=1 -> IDLE next cycle.
//  4. CMP model never raises Flag, TIMEOUT_CYCLES=4 -> Out_Valid with ALU_OUT=0, Timeout_Err=1 after 4 WAIT cycles.
//  5. Logic op issued, shift model raises spurious Shift_Flag in WAIT -> ignored; result taken from Logic_Flag/Logic_OUT.
//  6. RST=0 during ISSUE -> Enable falls asynchronously, all outputs 0, Req_Ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: unit-select codes, FSM states,
// default widths and the unit-to-enable decode.
package alu_pkg;

   localparam int DEF_IN_DATA_WIDTH  = 16;
   localparam int DEF_OUT_DATA_WIDTH = 16;
   localparam int DEF_TIMEOUT_CYCLES = 4;

   typedef enum logic [1:0] {
      UNIT_ARITH = 2'b00,
      UNIT_LOGIC = 2'b01,
      UNIT_CMP   = 2'b10,
      UNIT_SHIFT = 2'b11
   } unit_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_HOLD  = 2'b11
   } state_e;

   // Bit n of the enable vector belongs to the unit whose select code is n.
   function automatic logic [3:0] unit_onehot(input unit_e unit);
      unit_onehot = 4'b0001 << unit;
   endfunction

endpackage

// File: rtl/alu_unit_mux.sv
// Selects the result and result-valid flag of one ALU sub-unit by unit-select code.
module alu_unit_mux
   import alu_pkg::*;
#(
   parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH
) (
   input  logic [1:0]                unit_sel_i,
   input  logic [OUT_DATA_WIDTH-1:0] arith_out_i,
   input  logic [OUT_DATA_WIDTH-1:0] logic_out_i,
   input  logic [OUT_DATA_WIDTH-1:0] cmp_out_i,
   input  logic [OUT_DATA_WIDTH-1:0] shift_out_i,
   input  logic                      arith_flag_i,
   input  logic                      logic_flag_i,
   input  logic                      cmp_flag_i,
   input  logic                      shift_flag_i,
   output logic [OUT_DATA_WIDTH-1:0] sel_out_o,
   output logic                      sel_flag_o
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      sel_out_o  = '0;
      sel_flag_o = 1'b0;
      case (unit_e'(unit_sel_i))
         UNIT_ARITH: begin sel_out_o = arith_out_i; sel_flag_o = arith_flag_i; end
         UNIT_LOGIC: begin sel_out_o = logic_out_i; sel_flag_o = logic_flag_i; end
         UNIT_CMP:   begin sel_out_o = cmp_out_i;   sel_flag_o = cmp_flag_i;   end
         UNIT_SHIFT: begin sel_out_o = shift_out_i; sel_flag_o = shift_flag_i; end
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU sub-unit interface: accepts one op, pulses the selected
// unit's Enable, captures its result (or a timeout) and hands it downstream.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
   parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      Req_Valid,
   output logic                      Req_Ready,
   input  logic [IN_DATA_WIDTH-1:0]  Req_A,
   input  logic [IN_DATA_WIDTH-1:0]  Req_B,
   input  logic [3:0]                Req_FUN,
   output logic [IN_DATA_WIDTH-1:0]  A,
   output logic [IN_DATA_WIDTH-1:0]  B,
   output logic [1:0]                ALU_FUN,
   output logic                      Arith_Enable,
   output logic                      Logic_Enable,
   output logic                      CMP_Enable,
   output logic                      Shift_Enable,
   input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
   input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
   input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
   input  logic [OUT_DATA_WIDTH-1:0] Shift_OUT,
   input  logic                      Arith_Flag,
   input  logic                      Logic_Flag,
   input  logic                      CMP_Flag,
   input  logic                      Shift_Flag,
   output logic [OUT_DATA_WIDTH-1:0] ALU_OUT,
   output logic                      Out_Valid,
   input  logic                      Out_Ready,
   output logic                      Timeout_Err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                    state_q, state_d;
   unit_e                     unit_q, unit_d;
   logic [IN_DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [1:0]                fun_q, fun_d;
   logic [3:0]                en_q, en_d;
   logic [OUT_DATA_WIDTH-1:0] out_q, out_d;
   logic                      valid_q, valid_d;
   logic                      err_q, err_d;
   logic                      rdy_q, rdy_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   logic [OUT_DATA_WIDTH-1:0] sel_out;
   logic                      sel_flag;
   logic                      timeout;

   alu_unit_mux #(
      .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
   ) u_unit_mux (
      .unit_sel_i   (unit_q),
      .arith_out_i  (Arith_OUT),
      .logic_out_i  (Logic_OUT),
      .cmp_out_i    (CMP_OUT),
      .shift_out_i  (Shift_OUT),
      .arith_flag_i (Arith_Flag),
      .logic_flag_i (Logic_Flag),
      .cmp_flag_i   (CMP_Flag),
      .shift_flag_i (Shift_Flag),
      .sel_out_o    (sel_out),
      .sel_flag_o   (sel_flag)
   );

   assign timeout = (cnt_q == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         unit_q  <= UNIT_ARITH;
         a_q     <= '0;
         b_q     <= '0;
         fun_q   <= '0;
         en_q    <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         unit_q  <= unit_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fun_q   <= fun_d;
         en_q    <= en_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
      end
   end

   // Flag is checked before the timeout, so a result on the last WAIT cycle wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (Req_Valid)           state_d = ST_ISSUE;
         ST_ISSUE:                          state_d = ST_WAIT;
         ST_WAIT:  if (sel_flag || timeout) state_d = ST_HOLD;
         ST_HOLD:  if (Out_Ready)           state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      unit_d  = unit_q;
      a_d     = a_q;
      b_d     = b_q;
      fun_d   = fun_q;
      en_d    = '0;
      out_d   = out_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rdy_d   = (state_d == ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (Req_Valid) begin
               unit_d = unit_e'(Req_FUN[3:2]);
               a_d    = Req_A;
               b_d    = Req_B;
               fun_d  = Req_FUN[1:0];
               en_d   = unit_onehot(unit_e'(Req_FUN[3:2]));
            end
         end
         ST_ISSUE: cnt_d = '0;
         ST_WAIT: begin
            if (sel_flag) begin
               out_d   = sel_out;
               err_d   = 1'b0;
               valid_d = 1'b1;
            end else if (timeout) begin
               out_d   = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: if (Out_Ready) valid_d = 1'b0;
      endcase
   end

   assign Req_Ready    = rdy_q;
   assign A            = a_q;
   assign B            = b_q;
   assign ALU_FUN      = fun_q;
   assign Arith_Enable = en_q[UNIT_ARITH];
   assign Logic_Enable = en_q[UNIT_LOGIC];
   assign CMP_Enable   = en_q[UNIT_CMP];
   assign Shift_Enable = en_q[UNIT_SHIFT];
   assign ALU_OUT      = out_q;
   assign Out_Valid    = valid_q;
   assign Timeout_Err  = err_q;

endmodule
